channel_rr_arbiter: RTL and testbench

- Shares one blocking-channel input port among NUM_REQ requesters, e.g. several processing units feeding a single inter-FPGA or controller channel.
- Arbitration is round-robin.
- The winning word is captured in a single output register, which drives the downstream channel's in_data/in_valid.
- No combinational path exists from out_is_full to out_valid. The arbiter also reports an idle flag for the controller's convergence detection.

---
 rtl/helios_arb_pkg.sv | 7 +
 rtl/rr_priority_encoder.sv | 23 ++
 rtl/channel_rr_arbiter.sv | 51 +++++
 tb/tb_channel_rr_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/helios_arb_pkg.sv
// helios_arb_pkg: shared arbitration helpers
package helios_arb_pkg;
  function automatic int first_set(input logic [31:0] v);
    first_set = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) first_set = i;
  endfunction
endpackage

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: round-robin pick of the first set request at or after ptr
module rr_priority_encoder
  import helios_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);
  localparam logic [2*N-1:0] ONE = 1;
  logic [2*N-1:0] dbl, masked, lsb;
  // upper copy of req supplies the wrapped-around candidates below ptr
  assign dbl = {req, req};
  assign masked = dbl & ~((ONE << ptr) - ONE);
  assign lsb = masked & (~masked + ONE);
  assign gnt_onehot = lsb[N-1:0] | lsb[2*N-1:N];
  assign gnt_idx = PW'(first_set(32'(gnt_onehot)));
  assign any = |req;
endmodule

// File: rtl/channel_rr_arbiter.sv
// channel_rr_arbiter: round-robin share of one blocking channel among NUM_REQ requesters
module channel_rr_arbiter
  import helios_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     initialize,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_is_taken,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_is_full,
  output logic [PTR_W-1:0]         last_grant,
  output logic                     idle
);
  logic [PTR_W-1:0] rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic any, load_en, grant, clr;
  rr_priority_encoder #(.N(NUM_REQ)) u_enc (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt_onehot(gnt_onehot),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  assign clr = reset || initialize;
  assign load_en = !out_valid || !out_is_full;
  assign grant = load_en && any && !clr;
  assign req_is_taken = grant ? gnt_onehot : '0;
  assign idle = !out_valid && !(|req_valid);
  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid <= 1'b0;
      out_data <= '0;
      rr_ptr <= '0;
      last_grant <= '0;
    end else if (grant) begin
      out_data <= req_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_valid <= 1'b1;
      last_grant <= gnt_idx;
      rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end else if (!out_is_full) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_channel_rr_arbiter.sv
// tb_channel_rr_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_channel_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 0, reset = 0, initialize = 0, out_is_full = 0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_valid = '0, req_is_taken;
  logic [W-1:0] out_data;
  logic out_valid, idle;
  logic [1:0] last_grant;
  int pass_cnt = 0, total_cnt = 0;
  int m_ptr = 0, m_last = 0;
  logic m_valid = 0;
  logic [W-1:0] m_data = 0;

  channel_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .initialize(initialize), .req_data(req_data),
    .req_valid(req_valid), .req_is_taken(req_is_taken), .out_data(out_data),
    .out_valid(out_valid), .out_is_full(out_is_full), .last_grant(last_grant), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic int pick();
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_taken();
    int g = pick();
    if (reset || initialize || g < 0 || (m_valid && out_is_full)) return '0;
    return N'(1) << g;
  endfunction

  task automatic tick();
    int g = pick();
    if (reset || initialize) begin
      m_valid = 0; m_data = 0; m_ptr = 0; m_last = 0;
    end else if ((!m_valid || !out_is_full) && g >= 0) begin
      m_valid = 1; m_data = req_data[g*W +: W]; m_last = g; m_ptr = (g + 1) % N;
    end else if (!out_is_full) m_valid = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; initialize = 0; req_valid = '0; out_is_full = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; req_valid = '1; req_data = 32'h44332211;
    #1;
    total_cnt++; if (req_is_taken !== 4'b0) $display("FAIL reset_taken got %b want 0000", req_is_taken); else pass_cnt++;
    tick();
    reset = 0; req_valid = '0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else pass_cnt++;
    total_cnt++; if (last_grant !== 2'd0) $display("FAIL reset_last got %0d want 0", last_grant); else pass_cnt++;
    total_cnt++; if (idle !== 1'b1) $display("FAIL reset_idle got %b want 1", idle); else pass_cnt++;
  endtask

  task automatic test_all_valid();
    logic [7:0] words [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [3:0] oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req_valid = 4'b1111; req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      #1;
      total_cnt++; if (req_is_taken !== oh[k]) $display("FAIL all_taken[%0d] got %b want %b", k, req_is_taken, oh[k]); else pass_cnt++;
      tick();
      total_cnt++; if (out_data !== words[k] || out_valid !== 1'b1) $display("FAIL all_data[%0d] got %h/%b want %h/1", k, out_data, out_valid, words[k]); else pass_cnt++;
    end
  endtask

  task automatic test_single_and_wrap();
    do_reset();
    req_valid = 4'b0100; req_data = 32'h00A20000;
    #1;
    total_cnt++; if (req_is_taken !== 4'b0100) $display("FAIL single_taken got %b want 0100", req_is_taken); else pass_cnt++;
    tick();
    total_cnt++; if (out_data !== 8'hA2 || last_grant !== 2'd2) $display("FAIL single_out got %h/%0d want a2/2", out_data, last_grant); else pass_cnt++;
    req_valid = 4'b1001; req_data = 32'hB30000B0;
    #1;
    total_cnt++; if (req_is_taken !== 4'b1000) $display("FAIL wrap_taken3 got %b want 1000", req_is_taken); else pass_cnt++;
    tick();
    total_cnt++; if (out_data !== 8'hB3 || last_grant !== 2'd3) $display("FAIL wrap_out3 got %h/%0d want b3/3", out_data, last_grant); else pass_cnt++;
    req_data = 32'hC30000B0;
    #1;
    total_cnt++; if (req_is_taken !== 4'b0001) $display("FAIL wrap_taken0 got %b want 0001", req_is_taken); else pass_cnt++;
    tick();
    total_cnt++; if (out_data !== 8'hB0 || last_grant !== 2'd0) $display("FAIL wrap_out0 got %h/%0d want b0/0", out_data, last_grant); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 4'b0001; req_data = 32'h00000055;
    tick();
    req_valid = 4'b1111; req_data = 32'h13121166; out_is_full = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total_cnt++; if (req_is_taken !== 4'b0) $display("FAIL stall_taken[%0d] got %b want 0000", k, req_is_taken); else pass_cnt++;
      tick();
      total_cnt++; if (out_data !== 8'h55 || out_valid !== 1'b1) $display("FAIL stall_hold[%0d] got %h/%b want 55/1", k, out_data, out_valid); else pass_cnt++;
    end
    out_is_full = 0;
    #1;
    total_cnt++; if (req_is_taken !== 4'b0010 || $countones(req_is_taken) != 1) $display("FAIL stall_release got %b want 0010", req_is_taken); else pass_cnt++;
    tick();
    total_cnt++; if (out_data !== 8'h11) $display("FAIL stall_next got %h want 11", out_data); else pass_cnt++;
  endtask

  task automatic test_initialize();
    out_is_full = 1; initialize = 1; req_valid = 4'b1111;
    #1;
    total_cnt++; if (req_is_taken !== 4'b0) $display("FAIL init_taken got %b want 0000", req_is_taken); else pass_cnt++;
    tick();
    initialize = 0; req_valid = '0; out_is_full = 0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || idle !== 1'b1) $display("FAIL init_clear got %b/%b want 0/1", out_valid, idle); else pass_cnt++;
    req_valid = 4'b0110; req_data = 32'h00E2E100;
    #1;
    total_cnt++; if (req_is_taken !== 4'b0010) $display("FAIL init_first got %b want 0010", req_is_taken); else pass_cnt++;
    tick();
    total_cnt++; if (out_data !== 8'hE1 || last_grant !== 2'd1) $display("FAIL init_out got %h/%0d want e1/1", out_data, last_grant); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] pend_q [N][$];
    logic [W-1:0] sent_q [N][$];
    int seq [N] = '{0, 0, 0, 0};
    int waits [N] = '{0, 0, 0, 0};
    logic [N-1:0] presenting = '0;
    logic [N-1:0] et;
    logic [1:0] id;
    int received = 0, g;
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      id = 2'($urandom_range(0, N - 1));
      pend_q[id].push_back({id, 6'(seq[id])});
      seq[id]++;
    end
    for (int cyc = 0; cyc < 20000 && received < 1000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!presenting[i] && pend_q[i].size() > 0 && $urandom_range(0, 3) != 0) presenting[i] = 1;
        req_valid[i] = presenting[i];
        req_data[i*W +: W] = presenting[i] ? pend_q[i][0] : W'($urandom);
      end
      out_is_full = ($urandom_range(0, 2) == 0);
      #1;
      et = exp_taken();
      total_cnt++; if (req_is_taken !== et) $display("FAIL rand_taken cyc %0d got %b want %b", cyc, req_is_taken, et); else pass_cnt++;
      total_cnt++; if (out_valid !== m_valid || idle !== (!m_valid && req_valid == 0)) $display("FAIL rand_valid cyc %0d got %b/%b want %b", cyc, out_valid, idle, m_valid); else pass_cnt++;
      if (out_valid && !out_is_full) begin
        id = out_data[7:6];
        total_cnt++;
        if (sent_q[id].size() == 0 || sent_q[id][0] !== out_data) $display("FAIL rand_order got %h want %h", out_data, sent_q[id].size() ? sent_q[id][0] : 8'hxx);
        else pass_cnt++;
        if (sent_q[id].size() > 0) void'(sent_q[id].pop_front());
        received++;
      end
      g = (et != 0) ? $clog2(et) : -1;
      if (g >= 0) begin
        total_cnt++; if (waits[g] > N - 1) $display("FAIL rand_fair req %0d waited %0d want <= %0d", g, waits[g], N - 1); else pass_cnt++;
        for (int i = 0; i < N; i++) if (i != g && presenting[i]) waits[i]++;
      end
      tick();
      if (g >= 0) begin
        sent_q[g].push_back(pend_q[g].pop_front());
        presenting[g] = 0;
        waits[g] = 0;
      end
    end
    total_cnt++; if (received != 1000) $display("FAIL rand_count got %0d want 1000", received); else pass_cnt++;
    req_valid = '0; out_is_full = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_all_valid();
    test_single_and_wrap();
    test_stall();
    test_initialize();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
